udma_hyper_rx_packer: RTL and testbench
=======================================

Name: udma_hyper_rx_packer

Overview:
- Sits between the HyperBus controller read-data path and the uDMA RX linear channel.
- Accepts 16-bit halfwords (little-endian, 2 bytes per beat) from the controller and repacks them into uDMA RX beats of 8/16/32 bits according to the channel datasize.
- Buffers the packed beats in a small FIFO and enforces the transfer byte count.
- Generates a done pulse once all bytes have been delivered to the channel.

Parameters:
- TRANS_SIZE, 20, width of byte-count field (matches udma_pkg::TRANS_SIZE)
- FIFO_DEPTH, 4, output FIFO entries (32-bit), power of two, >=2

Ports:
- sys_clk_i  in  1  block clock
- rstn_i  in  1  asynchronous active-low reset
- clr_i  in  1  synchronous abort/flush
- start_i  in  1  pulse: latch cfg_size_i/cfg_datasize_i, begin transfer
- cfg_size_i  in  TRANS_SIZE  transfer length in bytes
- cfg_datasize_i  in  2  00=byte, 01=half, 10/11=word
- in_data_i  in  16  halfword from controller, byte0=[7:0]
- in_valid_i  in  1  halfword valid
- in_ready_o  out  1  halfword accepted when valid&ready
- out_data_o  out  32  packed beat, LSB-aligned, unused bits zero
- out_datasize_o  out  2  latched datasize (to rx_ch.datasize)
- out_valid_o  out  1  beat valid
- out_ready_i  in  1  channel ready
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse, transfer complete

Behaviour:
- Reset values: in_ready_o=0, out_valid_o=0, out_data_o=0, out_datasize_o=00, busy_o=0, done_o=0; FIFO empty, state IDLE.
- FSM states:
  - IDLE: start_i -> RUN; latch rem=cfg_size_i, unit=1/2/4 bytes, datasize.
  - RUN: packing.
  - DRAIN: entered when rem==0 and acc_cnt==0; waits for FIFO empty.
  - Exit: when FIFO is empty in DRAIN -> IDLE with done_o=1 for that cycle.
  - Zero-length start: cfg_size_i=0 goes RUN->DRAIN->IDLE; done_o pulses 2 cycles after start.
- Accumulator: acc[31:0], acc_cnt 0..4 bytes, LSB-first.
- Pop (push into FIFO), RUN only, requires FIFO not full and either:
  - acc_cnt>=unit: push acc[unit bytes], shift acc right by unit bytes, acc_cnt-=unit; or
  - rem==0 and 0<acc_cnt<unit: push zero-padded partial beat, acc_cnt=0.
  - At most one pop per cycle.
- Accept:
  - in_ready_o = RUN && rem!=0 && (acc_cnt - pop_bytes) <= 2, where pop_bytes is this cycle's pop.
  - in_ready_o must not depend on in_valid_i.
  - On accept: taken=min(2,rem); bytes appended at index acc_cnt-pop_bytes; rem-=taken.
  - With rem==1, the upper byte is discarded.
- Throughput: one halfword per cycle in half/word mode with out_ready_i=1. In byte mode the sustained input rate is one halfword per 2 cycles.
- Latency: halfword accepted at edge N -> popped at edge N+1 -> out_valid_o high after edge N+2 (FIFO registered, no fall-through).
- Output: out_valid_o = FIFO not empty. A FIFO pop occurs on out_valid_o&&out_ready_i. out_data_o holds stable while valid&&!ready.
- start_i while busy_o=1 is ignored.
- clr_i in any state: FIFO flushed, acc_cnt=0, rem=0, state IDLE, no done_o.
- clr_i and start_i in the same cycle: clr_i wins, start is dropped.
- Async reset mid-transfer: all state to reset values immediately.
- rem arithmetic is TRANS_SIZE bits, never underflows (taken<=rem).
- Datasize 11 is treated identically to 10.

Decomposition:
- hyper_pkg gets:
  - typedef enum logic[1:0] hyper_dsize_e {DS_BYTE, DS_HALF, DS_WORD}
  - packer FSM state enum
  - function dsize_to_bytes.
- One sub-module: io_generic_fifo (existing uDMA FIFO) instantiated with DATA_WIDTH=32, BUFFER_DEPTH=FIFO_DEPTH for the output buffer. Packing logic stays in the top.

Test Plan:
- Word mode, size=8, halfwords 0x2211,0x4433,0x6655,0x8877 back-to-back, ready=1 -> beats 0x44332211, 0x88776655; done_o pulse once after second beat drains.
- Byte mode, size=3, halfwords 0xBBAA,0xDDCC -> beats 0xAA, 0xBB, 0xCC (0xDD discarded); out_datasize_o=00; exactly 2 halfwords accepted.
- Word mode, size=6 -> second beat 0x0000FF EE-padded as 0x0000_xxyy (upper half zero); done_o after drain.
- Backpressure: half mode, size=16, out_ready_i=0 -> FIFO fills to FIFO_DEPTH, in_ready_o drops; release ready -> all 8 beats in order, no loss/duplication.
- clr_i asserted mid-transfer (after 2 beats) -> out_valid_o=0 next cycle, busy_o=0, no done_o; new start_i then runs cleanly.
- start_i with cfg_size_i=0 -> no in_ready_o, done_o pulse 2 cycles later; start_i during busy ignored (count unchanged).

Source files
------------

// File: rtl/hyper_pkg.sv
// rtl/hyper_pkg.sv - shared types and helpers for the HyperBus RX packing path
package hyper_pkg;

  typedef enum logic [1:0] {
    DS_BYTE = 2'b00,
    DS_HALF = 2'b01,
    DS_WORD = 2'b10
  } hyper_dsize_e;

  typedef enum logic [1:0] {
    PK_IDLE  = 2'b00,
    PK_RUN   = 2'b01,
    PK_DRAIN = 2'b10
  } packer_state_e;

  // Bytes per uDMA beat; encoding 11 behaves like a word
  function automatic logic [2:0] dsize_to_bytes(input logic [1:0] ds);
    case (ds)
      DS_BYTE: return 3'd1;
      DS_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// rtl/io_generic_fifo.sv - registered FIFO (no fall-through) used as the RX beat buffer
module io_generic_fifo #(
  parameter int DATA_WIDTH   = 32,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            clr_i,
  output logic [$clog2(BUFFER_DEPTH):0]   elements_o,
  output logic [DATA_WIDTH-1:0]           data_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  input  logic                            valid_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            ready_o
);

  localparam int AW = $clog2(BUFFER_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign elements_o = wr_ptr - rd_ptr;
  assign valid_o    = !empty;
  assign ready_o    = !full;
  assign push       = valid_i && !full;
  assign pop        = ready_i && !empty;
  assign data_o     = mem[rd_ptr[AW-1:0]];

  // Read/write pointers with an extra wrap bit; clr_i empties the buffer
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage, cleared on reset so data_o reads zero until the first write
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) mem[i] <= '0;
    end else if (push && !clr_i) begin
      mem[wr_ptr[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/udma_hyper_rx_packer.sv
// rtl/udma_hyper_rx_packer.sv - repacks HyperBus halfwords into uDMA RX beats with byte-count enforcement
module udma_hyper_rx_packer
  import hyper_pkg::*;
#(
  parameter int TRANS_SIZE = 20,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  sys_clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  start_i,
  input  logic [TRANS_SIZE-1:0] cfg_size_i,
  input  logic [1:0]            cfg_datasize_i,
  input  logic [15:0]           in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [31:0]           out_data_o,
  output logic [1:0]            out_datasize_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  packer_state_e         state;
  logic [TRANS_SIZE-1:0] rem;
  logic [2:0]            unit;
  logic [1:0]            dsize;
  logic [31:0]           acc;
  logic [2:0]            acc_cnt;
  logic                  stage_valid;
  logic [31:0]           stage_data;
  logic                  done_q;

  logic [AW:0]           fifo_elems;
  logic                  fifo_valid;
  logic                  fifo_ready;
  logic [AW+1:0]         occ;
  logic                  slot_ok;
  logic                  is_run;
  logic                  rem_zero;
  logic                  pop_full;
  logic                  pop_part;
  logic                  pop;
  logic [2:0]            pop_bytes;
  logic [2:0]            base;
  logic                  accept;
  logic [1:0]            taken;
  logic [31:0]           push_data;
  logic [31:0]           acc_shift;
  logic [31:0]           acc_nxt;
  logic [2:0]            acc_cnt_nxt;

  assign is_run   = (state == PK_RUN);
  assign rem_zero = (rem == '0);

  // A beat waiting in the stage register already owns a FIFO slot
  assign occ     = {1'b0, fifo_elems} + {{(AW+1){1'b0}}, stage_valid};
  assign slot_ok = fifo_ready && (occ < (AW+2)'(FIFO_DEPTH));

  assign pop_full  = is_run && (acc_cnt >= unit);
  assign pop_part  = is_run && rem_zero && (acc_cnt != 3'd0) && (acc_cnt < unit);
  assign pop       = (pop_full || pop_part) && slot_ok;
  assign pop_bytes = !pop ? 3'd0 : (pop_full ? unit : acc_cnt);
  assign base      = acc_cnt - pop_bytes;

  assign in_ready_o = is_run && !rem_zero && (base <= 3'd2);
  assign accept     = in_valid_i && in_ready_o;
  assign taken      = (rem >= TRANS_SIZE'(2)) ? 2'd2 : 2'd1;

  // Beat leaving the accumulator: low pop_bytes bytes, rest zero
  always_comb begin
    case (pop_bytes)
      3'd1:    push_data = {24'h0, acc[7:0]};
      3'd2:    push_data = {16'h0, acc[15:0]};
      3'd3:    push_data = {8'h0, acc[23:0]};
      default: push_data = acc;
    endcase
  end

  // Accumulator after removing the popped bytes (LSB-first)
  always_comb begin
    case (pop_bytes)
      3'd0:    acc_shift = acc;
      3'd1:    acc_shift = {8'h0, acc[31:8]};
      3'd2:    acc_shift = {16'h0, acc[31:16]};
      3'd3:    acc_shift = {24'h0, acc[31:24]};
      default: acc_shift = 32'h0;
    endcase
  end

  // Append accepted bytes right after the surviving ones; a dropped upper byte is never written
  always_comb begin
    acc_nxt = acc_shift;
    if (accept) begin
      for (int b = 0; b < 4; b++) begin
        if (3'(b) == base)
          acc_nxt[8*b +: 8] = in_data_i[7:0];
        else if ((taken == 2'd2) && (3'(b) == base + 3'd1))
          acc_nxt[8*b +: 8] = in_data_i[15:8];
      end
    end
  end

  assign acc_cnt_nxt = accept ? (base + {1'b0, taken}) : base;

  // Control FSM, byte counter, accumulator and FIFO stage register
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= PK_IDLE;
      rem         <= '0;
      unit        <= 3'd1;
      dsize       <= 2'b00;
      acc         <= '0;
      acc_cnt     <= '0;
      stage_valid <= 1'b0;
      stage_data  <= '0;
      done_q      <= 1'b0;
    end else if (clr_i) begin
      state       <= PK_IDLE;
      rem         <= '0;
      acc         <= '0;
      acc_cnt     <= '0;
      stage_valid <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      stage_valid <= pop;
      if (pop) stage_data <= push_data;
      acc     <= acc_nxt;
      acc_cnt <= acc_cnt_nxt;
      if (accept) rem <= rem - TRANS_SIZE'(taken);
      case (state)
        PK_IDLE: begin
          if (start_i) begin
            state <= PK_RUN;
            rem   <= cfg_size_i;
            unit  <= dsize_to_bytes(cfg_datasize_i);
            dsize <= cfg_datasize_i;
          end
        end
        PK_RUN: begin
          if (rem_zero && (acc_cnt == 3'd0)) state <= PK_DRAIN;
        end
        PK_DRAIN: begin
          if (!fifo_valid && !stage_valid) begin
            state  <= PK_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= PK_IDLE;
      endcase
    end
  end

  io_generic_fifo #(
    .DATA_WIDTH   (32),
    .BUFFER_DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk_i      (sys_clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (clr_i),
    .elements_o (fifo_elems),
    .data_o     (out_data_o),
    .valid_o    (fifo_valid),
    .ready_i    (out_ready_i),
    .valid_i    (stage_valid),
    .data_i     (stage_data),
    .ready_o    (fifo_ready)
  );

  assign out_valid_o    = fifo_valid;
  assign out_datasize_o = dsize;
  assign busy_o         = (state != PK_IDLE);
  assign done_o         = done_q;

endmodule

// File: tb/tb_udma_hyper_rx_packer.sv
// tb/tb_udma_hyper_rx_packer.sv - directed self-checking bench for udma_hyper_rx_packer
module tb_udma_hyper_rx_packer;

  logic        clk;
  logic        rstn;
  logic        clr;
  logic        start;
  logic [19:0] cfg_size;
  logic [1:0]  cfg_ds;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_ds;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt_tb = 0;
  logic [31:0] beats [$];

  udma_hyper_rx_packer #(.TRANS_SIZE(20), .FIFO_DEPTH(4)) dut (
    .sys_clk_i      (clk),
    .rstn_i         (rstn),
    .clr_i          (clr),
    .start_i        (start),
    .cfg_size_i     (cfg_size),
    .cfg_datasize_i (cfg_ds),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .out_data_o     (out_data),
    .out_datasize_o (out_ds),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .busy_o         (busy),
    .done_o         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record handshakes half a cycle away from the active edge
  always @(negedge clk) begin
    if (out_valid && out_ready) beats.push_back(out_data);
    if (done) done_cnt++;
    if (in_valid && in_ready) acc_cnt_tb++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_at(input int i);
    if (i < beats.size()) return beats[i];
    return 32'hBAD0BAD0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [19:0] sz, input logic [1:0] ds);
    cfg_size = sz;
    cfg_ds   = ds;
    start    = 1'b1;
    cyc(1);
    start    = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int budget, output logic ok);
    in_data  = d;
    in_valid = 1'b1;
    ok       = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    if (ok) in_valid = 1'b0;
  endtask

  task automatic send_ok(input logic [15:0] d, input string tag);
    logic ok;
    send(d, 50, ok);
    chk(tag, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_done(input int prev, input string tag);
    for (int n = 0; n < 100 && done_cnt <= prev; n++) cyc(1);
    cyc(3);
    chk(tag, done_cnt, prev + 1);
  endtask

  initial begin
    int   b0;
    int   dn;
    logic ok;
    logic released;

    rstn = 1'b0; clr = 1'b0; start = 1'b0; cfg_size = '0; cfg_ds = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ds", out_ds, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    cyc(2);

    // Word mode, 8 bytes
    dn = done_cnt; b0 = beats.size();
    do_start(20'd8, 2'b10);
    chk("w8_ds", out_ds, 2'b10);
    chk("w8_busy", busy, 1);
    send_ok(16'h2211, "w8_s0");
    send_ok(16'h4433, "w8_s1");
    send_ok(16'h6655, "w8_s2");
    send_ok(16'h8877, "w8_s3");
    wait_done(dn, "w8_done");
    chk("w8_nbeats", beats.size() - b0, 2);
    chk("w8_beat0", beat_at(b0), 32'h44332211);
    chk("w8_beat1", beat_at(b0 + 1), 32'h88776655);
    chk("w8_idle", busy, 0);

    // Byte mode, 3 bytes, upper byte of second halfword dropped
    dn = done_cnt; b0 = beats.size(); acc_cnt_tb = 0;
    do_start(20'd3, 2'b00);
    chk("b3_ds", out_ds, 2'b00);
    send_ok(16'hBBAA, "b3_s0");
    send_ok(16'hDDCC, "b3_s1");
    send(16'hFFEE, 6, ok);
    chk("b3_no_third", {31'b0, ok}, 0);
    in_valid = 1'b0;
    wait_done(dn, "b3_done");
    chk("b3_accepts", acc_cnt_tb, 2);
    chk("b3_nbeats", beats.size() - b0, 3);
    chk("b3_beat0", beat_at(b0), 32'h000000AA);
    chk("b3_beat1", beat_at(b0 + 1), 32'h000000BB);
    chk("b3_beat2", beat_at(b0 + 2), 32'h000000CC);

    // Word mode (encoding 11), 6 bytes -> padded tail beat
    dn = done_cnt; b0 = beats.size();
    do_start(20'd6, 2'b11);
    send_ok(16'h2211, "w6_s0");
    send_ok(16'h4433, "w6_s1");
    send_ok(16'hFFEE, "w6_s2");
    wait_done(dn, "w6_done");
    chk("w6_nbeats", beats.size() - b0, 2);
    chk("w6_beat0", beat_at(b0), 32'h44332211);
    chk("w6_beat1", beat_at(b0 + 1), 32'h0000FFEE);

    // Backpressure, half mode, 16 bytes
    dn = done_cnt; b0 = beats.size(); released = 1'b0;
    out_ready = 1'b0;
    do_start(20'd16, 2'b01);
    for (int i = 0; i < 8; i++) begin
      send(16'h1000 + 16'(i), 12, ok);
      if (!ok) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_hold_data", out_data, 32'h00001000);
        chk("bp_none_taken", beats.size() - b0, 0);
        released  = 1'b1;
        out_ready = 1'b1;
        send(16'h1000 + 16'(i), 50, ok);
        chk("bp_resend", {31'b0, ok}, 1);
      end
    end
    in_valid = 1'b0;
    chk("bp_stalled", {31'b0, released}, 1);
    out_ready = 1'b1;
    wait_done(dn, "bp_done");
    chk("bp_nbeats", beats.size() - b0, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("bp_beat%0d", i), beat_at(b0 + i), 32'h00001000 + 32'(i));

    // Abort mid-transfer
    dn = done_cnt; b0 = beats.size();
    do_start(20'd16, 2'b10);
    send_ok(16'h0201, "clr_s0");
    send_ok(16'h0403, "clr_s1");
    send_ok(16'h0605, "clr_s2");
    send_ok(16'h0807, "clr_s3");
    for (int n = 0; n < 50 && beats.size() < b0 + 2; n++) cyc(1);
    chk("clr_beat0", beat_at(b0), 32'h04030201);
    chk("clr_beat1", beat_at(b0 + 1), 32'h08070605);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_in_ready", in_ready, 0);
    cyc(5);
    chk("clr_no_done", done_cnt, dn);
    clr = 1'b1; start = 1'b1; cfg_size = 20'd4; cfg_ds = 2'b10;
    cyc(1);
    clr = 1'b0; start = 1'b0;
    cyc(1);
    chk("clr_wins_start", busy, 0);
    b0 = beats.size();
    do_start(20'd4, 2'b10);
    send_ok(16'hBEEF, "clr_r0");
    send_ok(16'hDEAD, "clr_r1");
    wait_done(dn, "clr_r_done");
    chk("clr_r_beat", beat_at(b0), 32'hDEADBEEF);

    // Zero-length transfer; start during busy ignored
    dn = done_cnt;
    do_start(20'd0, 2'b10);
    chk("z_busy", busy, 1);
    chk("z_in_ready0", in_ready, 0);
    chk("z_done0", done, 0);
    start = 1'b1; cfg_size = 20'd5;
    cyc(1);
    chk("z_in_ready1", in_ready, 0);
    chk("z_done1", done, 0);
    start = 1'b0;
    cyc(1);
    chk("z_done_pulse", done, 1);
    chk("z_idle", busy, 0);
    cyc(1);
    chk("z_done_low", done, 0);
    chk("z_still_idle", busy, 0);
    cyc(3);
    chk("z_done_count", done_cnt, dn + 1);

    // Asynchronous reset mid-transfer
    do_start(20'd8, 2'b10);
    send_ok(16'h3322, "ar_s0");
    send_ok(16'h5544, "ar_s1");
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, 0);
    cyc(1);
    rstn = 1'b1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
